cdc_hs_tx: RTL and testbench

- Source-domain end of a 4-phase req/ack CDC handshake.
- Accepts a word on a valid/ready interface and launches it on a stable bus with a level request.
- Waits for the far domain's acknowledge, synchronized internally, to complete the full 4-phase cycle before taking the next word.
- It is the transmitter counterpart of the receive-side synchronizers that sample req/data in the destination domain.

---
 rtl/cdc_hs_tx_pkg.sv | 9 +
 rtl/cdc_hs_tx_syn_chain.sv | 13 +
 rtl/cdc_hs_tx.sv | 72 +++++++
 tb/tb_cdc_hs_tx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cdc_hs_tx_pkg.sv
// cdc_hs_tx_pkg: state encoding for the cdc_hs_tx handshake FSM
package cdc_hs_tx_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        DROP  = 2'd3
    } hs_state_t;
endpackage

// File: rtl/cdc_hs_tx_syn_chain.sv
// syn_chain_h: SYN_LEVER-deep 1-bit synchronizer, sync reset to 0
module syn_chain_h #(
    parameter int SYN_LEVER = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYN_LEVER-1:0] sh;
    always_ff @(posedge clk) sh <= rst ? '0 : {sh[SYN_LEVER-2:0], d};
    assign q = sh[SYN_LEVER-1];
endmodule

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source side of a 4-phase req/ack CDC handshake with watchdog
module cdc_hs_tx
    import cdc_hs_tx_pkg::*;
#(
    parameter int DW        = 32,
    parameter int SYN_LEVER = 2,
    parameter int TMO_W     = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          req_asyn,
    output logic [DW-1:0] data_asyn,
    input  logic          ack_asyn,
    output logic          tx_done,
    output logic          tmo_err
);
    hs_state_t        state;
    logic             ack_syn;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
    syn_chain_h #(.SYN_LEVER(SYN_LEVER)) u_ack_syn (
        .clk(CLK),
        .rst(RST),
        .d  (ack_asyn),
        .q  (ack_syn)
    );
    // a stale or spurious ack blocks new work until the far side has let go
    assign in_ready = (state == IDLE) & ~ack_syn & ~RST;
    assign tmo_nxt  = &tmo_cnt ? tmo_cnt : tmo_cnt + 1'b1;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            req_asyn  <= 1'b0;
            data_asyn <= '0;
            tmo_cnt   <= '0;
            tmo_err   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    data_asyn <= in_data;
                    state     <= SETUP;
                end
                SETUP: begin
                    req_asyn <= 1'b1;
                    tmo_cnt  <= '0;
                    state    <= REQ;
                end
                REQ: begin
                    tmo_cnt <= tmo_nxt;
                    tmo_err <= tmo_err | &tmo_nxt;
                    if (ack_syn) begin
                        req_asyn <= 1'b0;
                        state    <= DROP;
                    end
                end
                DROP: begin
                    tmo_cnt <= tmo_nxt;
                    tmo_err <= tmo_err | &tmo_nxt;
                    if (!ack_syn) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: directed + randomized checks of cdc_hs_tx against a transaction-timing model
module tb_cdc_hs_tx;
    localparam int SL = 2;
    localparam int MIN_GAP = 3 + 2 * SL;
    localparam int TMO_CYC = 15;
    logic        CLK = 1'b0;
    logic        RST, in_valid, ack_asyn;
    logic [31:0] in_data;
    logic        in_ready, req_asyn, tx_done, tmo_err;
    logic [31:0] data_asyn;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit tmo_m = 1'b0;
    cdc_hs_tx #(.DW(32), .SYN_LEVER(SL), .TMO_W(4)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .req_asyn(req_asyn), .data_asyn(data_asyn),
        .ack_asyn(ack_asyn), .tx_done(tx_done), .tmo_err(tmo_err)
    );
    always #5 CLK = ~CLK;
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // One transfer: far side raises ack d cycles after req is visible, drops it e cycles after req falls.
    // Expected event times follow from the handshake rules: req high for edges 1..d+3 after accept,
    // tx_done and in_ready exactly at edge d+e+7, watchdog flag after TMO_CYC+1 edges.
    task automatic xfer(input logic [31:0] w, input int d, input int e, input bit bp, output int t0);
        int n;
        n = d + e + 7;
        chk("rdy_pre", in_ready, 1);
        in_valid = 1'b1;
        in_data  = w;
        step();
        t0 = cyc;
        chk("load_data", data_asyn, w);
        chk("load_req", req_asyn, 0);
        chk("load_rdy", in_ready, 0);
        for (int k = 1; k <= n; k++) begin
            in_valid = bp;
            in_data  = $urandom;
            step();
            if (k >= TMO_CYC + 1) tmo_m = 1'b1;
            chk("req", req_asyn, (k <= d + 3) ? 1 : 0);
            chk("done", tx_done, (k == n) ? 1 : 0);
            chk("rdy", in_ready, (k == n) ? 1 : 0);
            chk("data_hold", data_asyn, w);
            chk("tmo", tmo_err, tmo_m);
            if (k == 1 + d) ack_asyn = 1'b1;
            if (k == d + 4 + e) ack_asyn = 1'b0;
        end
        in_valid = 1'b0;
    endtask
    initial begin
        int t_a, t_b, t_c;
        logic [31:0] w;
        RST = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        ack_asyn = 1'b0;
        repeat (3) step();
        chk("rst_req", req_asyn, 0);
        chk("rst_data", data_asyn, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_tmo", tmo_err, 0);
        chk("rst_rdy", in_ready, 0);
        RST = 1'b0;
        step();
        chk("post_rst_rdy", in_ready, 1);
        // basic transfer
        xfer(32'hDEADBEEF, 0, 0, 1'b0, t_a);
        // back-to-back with in_valid effectively held high
        xfer(32'h1, 0, 0, 1'b0, t_a);
        xfer(32'h2, 0, 0, 1'b0, t_b);
        xfer(32'h3, 0, 0, 1'b0, t_c);
        chk("gap_ab_min", (t_b - t_a) >= MIN_GAP, 1);
        chk("gap_bc_min", (t_c - t_b) >= MIN_GAP, 1);
        // backpressure: in_valid held with changing data while busy
        xfer(32'hA5A5_0001, 2, 1, 1'b1, t_a);
        step();
        chk("bp_no_capture", data_asyn, 32'hA5A5_0001);
        chk("bp_idle_req", req_asyn, 0);
        // randomized transfers
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            xfer(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), t_a);
        end
        // spurious ack in IDLE
        ack_asyn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 3) ack_asyn = 1'b0;
            chk("spur_rdy", in_ready, (k >= 2 && k <= 4) ? 0 : 1);
            chk("spur_req", req_asyn, 0);
            chk("spur_done", tx_done, 0);
        end
        // watchdog: late ack, flag is sticky across a later normal transfer
        xfer(32'h0BAD_F00D, 20, 2, 1'b0, t_a);
        chk("tmo_set", tmo_err, 1);
        xfer(32'h1234_5678, 1, 1, 1'b0, t_a);
        chk("tmo_sticky", tmo_err, 1);
        RST = 1'b1;
        step();
        tmo_m = 1'b0;
        chk("tmo_rst", tmo_err, 0);
        RST = 1'b0;
        step();
        // reset mid-transfer with the far side still acknowledging
        in_valid = 1'b1;
        in_data = 32'hCAFE_0042;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_req_up", req_asyn, 1);
        ack_asyn = 1'b1;
        step();
        RST = 1'b1;
        step();
        chk("mid_rst_req", req_asyn, 0);
        chk("mid_rst_data", data_asyn, 0);
        chk("mid_rst_done", tx_done, 0);
        RST = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k >= 2) chk("stale_rdy", in_ready, (k >= 12) ? 1 : 0);
            chk("stale_req", req_asyn, 0);
            if (k == 10) ack_asyn = 1'b0;
        end
        // recovery after stale ack
        xfer(32'h7777_8888, 1, 0, 1'b0, t_a);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
